alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU unit (e.g. NOT_op and the other N-bit ops with Z flag)
//  between two requesters. Round-robin grant, registers the operands and opcode that
//  drive the ALU, captures result and flagZ, returns them to the granted requester
//  over a valid/ready response channel. Sits between the control logic and the ALU.
// PARAMETERS
//  N    4  data width of operands/result
//  OPW  4  opcode width, passed through to the ALU unmodified
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  req_valid   in   2        bit i: requester i has an op pending
//  req_ready   out  2        bit i: op from requester i accepted this cycle
//  req_a       in   2*N      operand A; [N-1:0] req0, [2N-1:N] req1
//  req_b       in   2*N      operand B; same packing
//  req_op      in   2*OPW    opcode; same packing
//  alu_a       out  N        registered operand A to ALU
//  alu_b       out  N        registered operand B to ALU
//  alu_op      out  OPW      registered opcode to ALU
//  alu_result  in   N        ALU result (combinational from alu_*)
//  alu_flagZ   in   1        ALU zero flag
//  rsp_valid   out  1        response available
//  rsp_ready   in   1        consumer accepts response
//  rsp_id      out  1        requester the response belongs to
//  rsp_result  out  N        captured result
//  rsp_flagZ   out  1        captured zero flag
//  busy        out  1        high in ISSUE or RESP
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=1, alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_id=0,
//    rsp_result=0, rsp_flagZ=0, busy=0; req_ready forced 0 while rst_n=0.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE; one op in flight max.
//  - IDLE: grant g = the only valid requester; if both valid, g = ~last_grant.
//    req_ready[g]=1 combinationally (other bit 0); on the edge latch a/b/op of g into
//    alu_*, rsp_id<=g, last_grant<=g, go ISSUE. No valid -> stay IDLE, req_ready=0.
//  - req_ready is 0 in ISSUE and RESP; requesters hold req_* stable until ready.
//  - ISSUE (1 cycle): alu_* stable; on edge rsp_result<=alu_result,
//    rsp_flagZ<=alu_flagZ, rsp_valid<=1, go RESP.
//  - RESP: rsp_* held stable while rsp_valid=1 && rsp_ready=0 (any number of cycles).
//    rsp_valid && rsp_ready on edge -> rsp_valid<=0, go IDLE. rsp_ready ignored in
//    IDLE/ISSUE.
//  - Latency: accept edge to rsp_valid = 2 cycles; min 3 cycles per op (no overlap).
//  - alu_* keep last issued values outside ISSUE (no re-clear); rsp_result/flagZ keep
//    last value after handshake.
//  - No width arithmetic inside: operands/results passed at exactly N bits.
//  - Request arriving while busy: waits; fairness via last_grant, no starvation:
//    with both valid continuously, grants alternate 0,1,0,1...
//  - Reset mid-operation (ISSUE or RESP): in-flight op dropped, no response emitted,
//    all outputs to reset values immediately (async); first grant after reset goes
//    to requester 0 when both valid.
//  - Illegal state encodings recover to IDLE.
// TESTING  (bench ALU model: op 4'h2 = NOT, flagZ = result==0; N=4, OPW=4)
//  - Single req0 a=4'b1010 op=2, rsp_ready=1 -> ready0 1 cycle, rsp_valid 2 cycles
//    later, rsp_id=0, result=4'b0101, flagZ=0, busy high 2 cycles.
//  - req1 a=4'b1111 op=2 -> rsp_id=1, result=4'b0000, flagZ=1.
//  - Both valid from reset, rsp_ready=1, 4 ops -> grant order 0,1,0,1, each op
//    3 cycles apart; responses carry matching ids/results.
//  - rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, new req0 waits;
//    accepted the cycle after the handshake returns FSM to IDLE.
//  - rst_n pulled low during ISSUE -> rsp_valid stays 0, alu_*=0 at once; after
//    release, both valid -> requester 0 granted first.
//  - No requests for 10 cycles -> req_ready=0, busy=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Registers operands/opcode toward the ALU and returns result + zero flag over valid/ready.
module alu_share_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned OPW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*N-1:0]   req_a,
  input  logic [2*N-1:0]   req_b,
  input  logic [2*OPW-1:0] req_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_flagZ,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_flagZ,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0] state, state_nxt;
  logic       last_grant;
  logic       grant_c;
  logic       accept_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant selection and combinational accept strobe
  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    accept_c  = 1'b0;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          accept_c  = 1'b1;
          state_nxt = ISSUE;
          case (req_valid)
            2'b01:   grant_c = 1'b0;
            2'b10:   grant_c = 1'b1;
            default: grant_c = ~last_grant;
          endcase
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Ready is held low throughout reset even though the state decode is already IDLE
    if (accept_c && rst_n) begin
      req_ready = grant_c ? 2'b10 : 2'b01;
    end
  end

  // Operand capture, result capture and response flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flagZ  <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (accept_c) begin
        alu_a      <= grant_c ? req_a[2*N-1:N]     : req_a[N-1:0];
        alu_b      <= grant_c ? req_b[2*N-1:N]     : req_b[N-1:0];
        alu_op     <= grant_c ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
        rsp_id     <= grant_c;
        last_grant <= grant_c;
      end
      if (state == ISSUE) begin
        rsp_result <= alu_result;
        rsp_flagZ  <= alu_flagZ;
      end
      rsp_valid <= (state_nxt == RESP);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] req_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_flagZ;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_flagZ;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;

  alu_share_arbiter #(.N(4), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flagZ(alu_flagZ),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flagZ(rsp_flagZ), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: 0 add, 1 and, 2 not, others xor
  always_comb begin
    case (alu_op)
      4'h0:    alu_result = alu_a + alu_b;
      4'h1:    alu_result = alu_a & alu_b;
      4'h2:    alu_result = ~alu_a;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_flagZ = (alu_result == 4'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d result=%0h expected no response", rsp_id, rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e[5]));
        check("rsp_result", 32'(rsp_result), 32'(mon_e[4:1]));
        check("rsp_flagZ", 32'(rsp_flagZ), 32'(mon_e[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    if (id) begin
      req_a[7:4] = a; req_b[7:4] = b; req_op[7:4] = op;
    end else begin
      req_a[3:0] = a; req_b[3:0] = b; req_op[3:0] = op;
    end
  endtask

  // Present one request, wait for its grant, optionally log the expected response
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input bit push, input logic [4:0] re);
    bit got;
    got = 1'b0;
    drive(id, a, b, op);
    req_valid[id] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      #1;
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("accept", 32'(got), 32'd1);
    check("ready_onehot", 32'(req_ready), id ? 32'd2 : 32'd1);
    if (push) exp_q.push_back({id, re});
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int j = 0; j < 20; j++) begin
      #1;
      if (!busy && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] va[4];
    logic [3:0] vb[4];
    logic [3:0] vo[4];
    logic [4:0] vr[4];
    bit got;
    int last_cyc;

    rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("reset_rsp", 32'({rsp_id, rsp_result, rsp_flagZ}), 32'd0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 0: NOT 1010
    rsp_ready = 1'b1;
    issue(1'b0, 4'b1010, 4'b0000, 4'h2, 1'b1, {4'b0101, 1'b0});
    #1;
    check("t1_issue_busy", 32'(busy), 32'd1);
    check("t1_issue_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_alu_a", 32'(alu_a), 32'hA);
    check("t1_alu_op", 32'(alu_op), 32'h2);
    check("t1_issue_ready", 32'(req_ready), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_resp_busy", 32'(busy), 32'd1);
    tick();
    check("t1_done_valid", 32'(rsp_valid), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);

    // Single request from requester 1: NOT 1111 gives zero
    issue(1'b1, 4'b1111, 4'b0000, 4'h2, 1'b1, {4'b0000, 1'b1});
    tick();
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_id", 32'(rsp_id), 32'd1);
    tick();
    check("t2_done_valid", 32'(rsp_valid), 32'd0);

    // Quiet interval
    for (int k = 0; k < 10; k++) begin
      #1;
      check("idle_outputs", 32'({req_ready, busy, rsp_valid}), 32'd0);
      tick();
    end

    // Both valid from reset: grants alternate 0,1,0,1 three cycles apart
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    va[0] = 4'b0011; vb[0] = 4'b0101; vo[0] = 4'h0; vr[0] = {4'b1000, 1'b0};
    va[1] = 4'b1001; vb[1] = 4'b0111; vo[1] = 4'h0; vr[1] = {4'b0000, 1'b1};
    va[2] = 4'b0110; vb[2] = 4'b0000; vo[2] = 4'h2; vr[2] = {4'b1001, 1'b0};
    va[3] = 4'b1100; vb[3] = 4'b1010; vo[3] = 4'h1; vr[3] = {4'b1000, 1'b0};
    drive(1'b0, va[0], vb[0], vo[0]);
    drive(1'b1, va[1], vb[1], vo[1]);
    req_valid = 2'b11;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int j = 0; j < 10; j++) begin
        #1;
        if (req_ready != 2'b00) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      check("rr_accept", 32'(got), 32'd1);
      check("rr_grant", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      if (k > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
      exp_q.push_back({1'(k % 2), vr[k]});
      tick();
      if (k + 2 < 4) drive(1'(k % 2), va[k+2], vb[k+2], vo[k+2]);
      else req_valid[k % 2] = 1'b0;
    end
    wait_idle();

    // Stalled response: outputs hold, new request waits for the handshake
    rsp_ready = 1'b0;
    issue(1'b0, 4'b0000, 4'b0000, 4'h2, 1'b1, {4'b1111, 1'b0});
    tick();
    drive(1'b0, 4'b0101, 4'b0011, 4'h1);
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_result", 32'({rsp_id, rsp_result, rsp_flagZ}), 32'({1'b0, 4'b1111, 1'b0}));
      check("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("stall_then_accept", 32'(req_ready), 32'd1);
    exp_q.push_back({1'b0, 4'b0001, 1'b0});
    tick();
    req_valid = 2'b00;
    wait_idle();

    // Reset during ISSUE drops the op; requester 0 wins first after release
    issue(1'b1, 4'b0110, 4'b0000, 4'h2, 1'b0, 5'd0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("mid_reset_flags", 32'({busy, rsp_valid, req_ready}), 32'd0);
    drive(1'b0, 4'b1110, 4'b0000, 4'h2);
    drive(1'b1, 4'b0011, 4'b0000, 4'h2);
    req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("post_reset_grant", 32'(req_ready), 32'd1);
    exp_q.push_back({1'b0, 4'b0001, 1'b0});
    tick();
    req_valid = 2'b00;
    wait_idle();

    for (int j = 0; j < 20 && exp_q.size() != 0; j++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
